// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : 32x64 architectural register file, two bypassed read ports, one
//            write port, and a busy scoreboard for in-flight load destinations.
// Revision : 1.0 - initial release
// ============================================================================

// ============================================================================
// Module   : regfile_scoreboard_reg64
// Purpose  : Enabled register storage element, asynchronously cleared.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard_reg64 #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

module regfile_scoreboard #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  input  logic                rd_used1,
  input  logic                rd_used2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                mark_en,
  input  logic [ADDR_W-1:0]   mark_addr,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [5:0]          pending_cnt
);

  localparam logic [ADDR_W-1:0] c_zero = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]   w_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [5:0]          r_cnt;
  logic                w_wr_ok;
  logic                w_mark_ok;
  logic                w_inc;
  logic                w_dec;
  logic                w_byp1;
  logic                w_byp2;
  logic                w_eff1;
  logic                w_eff2;

  assign w_wr_ok   = wr_en   && (wr_addr   != c_zero);
  assign w_mark_ok = mark_en && (mark_addr != c_zero);

  // XZR has no storage at all; every other index gets an enabled register.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      if (gi == ZERO_REG) begin : g_zero
        assign w_regs[gi] = '0;
      end else begin : g_store
        logic w_we;
        assign w_we = w_wr_ok && (wr_addr == ADDR_W'(gi));
        regfile_scoreboard_reg64 #(
          .DATA_W (DATA_W)
        ) u_reg (
          .clk   (clk),
          .reset (reset),
          .i_en  (w_we),
          .i_d   (wr_data),
          .o_q   (w_regs[gi])
        );
      end
    end
  endgenerate

  assign w_byp1 = wr_en && (wr_addr == rd_addr1);
  assign w_byp2 = wr_en && (wr_addr == rd_addr2);

  always_comb begin
    rd_data1 = w_regs[rd_addr1];
    if (w_byp1) rd_data1 = wr_data;
    if (rd_addr1 == c_zero) rd_data1 = '0;
  end

  always_comb begin
    rd_data2 = w_regs[rd_addr2];
    if (w_byp2) rd_data2 = wr_data;
    if (rd_addr2 == c_zero) rd_data2 = '0;
  end

  // A write landing this cycle bypasses its data, so it no longer stalls.
  assign w_eff1 = r_busy[rd_addr1] && !w_byp1 && (rd_addr1 != c_zero);
  assign w_eff2 = r_busy[rd_addr2] && !w_byp2 && (rd_addr2 != c_zero);
  assign hazard = (rd_used1 && w_eff1) || (rd_used2 && w_eff2);

  // Clear first, then set, so a new load on the retiring register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)   w_busy_nxt[wr_addr]   = 1'b0;
    if (w_mark_ok) w_busy_nxt[mark_addr] = 1'b1;
  end

  assign w_inc = w_mark_ok && !r_busy[mark_addr];
  assign w_dec = w_wr_ok && r_busy[wr_addr] &&
                 !(w_mark_ok && (mark_addr == wr_addr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + 6'd1;
        2'b01:   r_cnt <= r_cnt - 6'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign busy_vec    = r_busy;
  assign pending_cnt = r_cnt;

endmodule
`default_nettype wire
